psubsb_serial: RTL and testbench



---
 rtl/psubsb_serial.sv | 154 +++++++++++++++
 tb/tb_psubsb_serial.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/psubsb_serial.sv
// rtl/psubsb_serial.sv - lane-serial saturating subtract, one LANE_W lane per cycle.
// Define PSUBSB_SATFLAG_EN to add the per-lane saturation flag output sat.
module psubsb_serial #(
   parameter int LANES  = 4,
   parameter int LANE_W = 4,
   localparam int W     = LANES * LANE_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [W-1:0] A,
   input  logic [W-1:0] B,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] Diff
`ifdef PSUBSB_SATFLAG_EN
   ,
   output logic [LANES-1:0] sat
`endif
);

   localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [W-1:0]       a_q, a_d;
   logic [W-1:0]       b_q, b_d;
   logic [W-1:0]       shadow_q, shadow_d;
   logic [W-1:0]       diff_q, diff_d;
   logic               done_q, done_d;

   logic [LANE_W-1:0]  lane_a, lane_b, lane_raw, lane_res;
   logic               lane_ovf;

`ifdef PSUBSB_SATFLAG_EN
   logic [LANES-1:0]   sat_sh_q, sat_sh_d;
   logic [LANES-1:0]   sat_q, sat_d;
`endif

   // Time-shared lane datapath: select the lane addressed by the counter.
   always_comb begin
      lane_a = '0;
      lane_b = '0;
      for (int k = 0; k < LANES; k++) begin
         if (cnt_q == CNT_W'(k)) begin
            lane_a = a_q[k*LANE_W +: LANE_W];
            lane_b = b_q[k*LANE_W +: LANE_W];
         end
      end
      lane_raw = lane_a + ~lane_b + {{(LANE_W-1){1'b0}}, 1'b1};
      lane_ovf = (lane_a[LANE_W-1] != lane_b[LANE_W-1]) &&
                 (lane_raw[LANE_W-1] != lane_a[LANE_W-1]);
      if (lane_ovf) begin
         lane_res = lane_a[LANE_W-1] ? {1'b1, {(LANE_W-1){1'b0}}}
                                     : {1'b0, {(LANE_W-1){1'b1}}};
      end else begin
         lane_res = lane_raw;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      a_d      = a_q;
      b_d      = b_q;
      shadow_d = shadow_q;
      diff_d   = diff_q;
      done_d   = 1'b0;
`ifdef PSUBSB_SATFLAG_EN
      sat_sh_d = sat_sh_q;
      sat_d    = sat_q;
`endif
      case (state_q)
         S_IDLE: begin
            // The done pulse cycle still belongs to the previous request.
            if (start && !done_q) begin
               a_d     = A;
               b_d     = B;
               cnt_d   = '0;
               state_d = S_CALC;
            end
         end
         S_CALC: begin
            for (int k = 0; k < LANES; k++) begin
               if (cnt_q == CNT_W'(k)) begin
                  shadow_d[k*LANE_W +: LANE_W] = lane_res;
`ifdef PSUBSB_SATFLAG_EN
                  sat_sh_d[k] = lane_ovf;
`endif
               end
            end
            if (cnt_q == CNT_W'(LANES - 1)) begin
               cnt_d   = '0;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DONE: begin
            diff_d  = shadow_q;
            done_d  = 1'b1;
`ifdef PSUBSB_SATFLAG_EN
            sat_d   = sat_sh_q;
`endif
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         shadow_q <= '0;
         diff_q   <= '0;
         done_q   <= 1'b0;
`ifdef PSUBSB_SATFLAG_EN
         sat_sh_q <= '0;
         sat_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         a_q      <= a_d;
         b_q      <= b_d;
         shadow_q <= shadow_d;
         diff_q   <= diff_d;
         done_q   <= done_d;
`ifdef PSUBSB_SATFLAG_EN
         sat_sh_q <= sat_sh_d;
         sat_q    <= sat_d;
`endif
      end
   end

   assign busy = (state_q == S_CALC);
   assign done = done_q;
   assign Diff = diff_q;
`ifdef PSUBSB_SATFLAG_EN
   assign sat  = sat_q;
`endif

endmodule

// File: tb/tb_psubsb_serial.sv
// tb/tb_psubsb_serial.sv - directed scoreboard bench for psubsb_serial.
// Honours PSUBSB_SATFLAG_EN when the design is built with it.
module tb_psubsb_serial;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [15:0] A, B;
   logic        busy, done;
   logic [15:0] Diff;
`ifdef PSUBSB_SATFLAG_EN
   logic [3:0]  sat;
`endif

   psubsb_serial #(.LANES(4), .LANE_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .A     (A),
      .B     (B),
      .busy  (busy),
      .done  (done),
      .Diff  (Diff)
`ifdef PSUBSB_SATFLAG_EN
      ,
      .sat   (sat)
`endif
   );

   always #5 clk = ~clk;

   logic [15:0] exp_diff_q[$];
   logic [3:0]  exp_sat_q[$];
   logic [15:0] last_diff;
   int          n_checks = 0;
   int          n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Reference: widen each lane to a signed integer, subtract, clamp to [-8,7].
   function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b);
      logic [15:0] r;
      logic [3:0]  s;
      logic [3:0]  la, lb;
      int          av, bv, d;
      r = '0;
      s = '0;
      for (int k = 0; k < 4; k++) begin
         la = a[k*4 +: 4];
         lb = b[k*4 +: 4];
         av = int'($signed(la));
         bv = int'($signed(lb));
         d  = av - bv;
         if (d > 7) begin
            d = 7;
            s[k] = 1'b1;
         end else if (d < -8) begin
            d = -8;
            s[k] = 1'b1;
         end
         r[k*4 +: 4] = 4'(d);
      end
      return {s, r};
   endfunction

   task automatic push_exp(input logic [15:0] a, input logic [15:0] b);
      logic [19:0] m;
      m = model(a, b);
      exp_diff_q.push_back(m[15:0]);
      exp_sat_q.push_back(m[19:16]);
   endtask

   task automatic pop_check(input string tag);
      logic [15:0] ed;
      logic [3:0]  es;
      if (exp_diff_q.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
         ed = exp_diff_q.pop_front();
         es = exp_sat_q.pop_front();
         last_diff = ed;
         chk({tag, "_diff"}, 32'(Diff), 32'(ed));
`ifdef PSUBSB_SATFLAG_EN
         chk({tag, "_sat"}, 32'(sat), 32'(es));
`else
         if (es === 4'hx) chk({tag, "_sat_x"}, 32'(es), 32'd0);
`endif
      end
   endtask

   // One request; optionally re-pulses start mid-CALC. A/B are scrambled after acceptance.
   task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                         input bit restart, input string tag);
      int busy_cnt;
      int done_cnt;
      int done_at;
      busy_cnt = 0;
      done_cnt = 0;
      done_at  = 0;
      push_exp(a, b);
      @(negedge clk);
      A = a;
      B = b;
      start = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (c == 1) begin
            start = 1'b0;
            A = ~a;
            B = ~b;
         end
         if (restart && c == 2) begin
            start = 1'b1;
            A = 16'hFFFF;
         end
         if (restart && c == 3) start = 1'b0;
         if (busy) busy_cnt++;
         if (done) begin
            done_cnt++;
            done_at = c;
            pop_check(tag);
         end
      end
      chk({tag, "_done_latency"}, 32'(done_at), 32'd6);
      chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd4);
      chk({tag, "_done_count"}, 32'(done_cnt), 32'd1);
      chk({tag, "_diff_held"}, 32'(Diff), 32'(last_diff));
   endtask

   initial begin
      int d_cnt;
      int d_at[$];
      logic [15:0] ra, rb;

      rst_n = 1'b0;
      start = 1'b0;
      A = '0;
      B = '0;
      last_diff = '0;
      repeat (3) @(negedge clk);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_diff", 32'(Diff), 32'd0);
`ifdef PSUBSB_SATFLAG_EN
      chk("reset_sat", 32'(sat), 32'd0);
`endif
      rst_n = 1'b1;
      @(negedge clk);

      run_op(16'h3210, 16'h1111, 1'b0, "basic");
      chk("basic_const", 32'(last_diff), 32'h210F);
      run_op(16'h7812, 16'h8111, 1'b0, "mixed_sat");
      chk("mixed_const", 32'(last_diff), 32'h7801);
      run_op(16'h0000, 16'h8888, 1'b0, "zero_minus_min");
      chk("zmm_const", 32'(last_diff), 32'h7777);
      run_op(16'h8888, 16'h8888, 1'b0, "min_minus_min");
      chk("mmm_const", 32'(last_diff), 32'h0000);
      run_op(16'h5A3C, 16'hC4E7, 1'b1, "restart_ignored");

      for (int i = 0; i < 4; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         run_op(ra, rb, 1'b0, $sformatf("rand%0d", i));
      end

      // Reset asserted in the second CALC cycle aborts the request silently.
      @(negedge clk);
      A = 16'h1234;
      B = 16'h4321;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_diff", 32'(Diff), 32'd0);
      rst_n = 1'b1;
      d_cnt = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (done) d_cnt++;
      end
      chk("abort_no_done", 32'(d_cnt), 32'd0);
      run_op(16'h3210, 16'h1111, 1'b0, "after_abort");

      // Start held high: accepted again only once the done cycle has passed.
      for (int i = 0; i < 3; i++) push_exp(16'h6F01, 16'h9F12);
      @(negedge clk);
      A = 16'h6F01;
      B = 16'h9F12;
      start = 1'b1;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         if (done) begin
            d_at.push_back(c);
            pop_check($sformatf("hold%0d", d_at.size()));
            if (d_at.size() == 3) start = 1'b0;
         end
      end
      chk("hold_done_count", 32'(d_at.size()), 32'd3);
      if (d_at.size() == 3) begin
         chk("hold_first", 32'(d_at[0]), 32'd6);
         chk("hold_period1", 32'(d_at[1] - d_at[0]), 32'd7);
         chk("hold_period2", 32'(d_at[2] - d_at[1]), 32'd7);
      end

      chk("sb_drained", 32'(exp_diff_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
